// File: rtl/arith_serial_pkg.sv
// arith_serial_pkg: shared width default and FSM states for the bit-serial arithmetic blocks
package arith_serial_pkg;
   localparam int DEF_WIDTH = 16;
   typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2} state_e;
endpackage

// File: rtl/serial_subtractor_16_if.sv
// serial_subtractor_16_if: operand/result valid-ready bundle of the serial subtractor
interface serial_subtractor_16_if #(parameter int WIDTH = 16);
   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             bin;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] diff;
   logic             bout;
   logic             ovf;
   modport master (output in_valid, a, b, bin, out_ready, input in_ready, out_valid, diff, bout, ovf);
   modport slave  (input in_valid, a, b, bin, out_ready, output in_ready, out_valid, diff, bout, ovf);
endinterface

// File: rtl/full_subtractor_cell.sv
// full_subtractor_cell: one-bit x - y - bi with borrow-out
module full_subtractor_cell (
   input  logic x,
   input  logic y,
   input  logic bi,
   output logic d,
   output logic bo
);
   assign d  = x ^ y ^ bi;
   assign bo = (~x & y) | (~(x ^ y) & bi);
endmodule

// File: rtl/serial_subtractor_16.sv
// serial_subtractor_16: LSB-first bit-serial a - b - bin with borrow-out and signed overflow
module serial_subtractor_16
   import arith_serial_pkg::*;
#(
   parameter int WIDTH = DEF_WIDTH
) (
   input logic                  clk,
   input logic                  rst,
   serial_subtractor_16_if.slave bus
);
   localparam int CW = $clog2(WIDTH);
   localparam logic [1:0] ST_IDLE = IDLE;
   localparam logic [1:0] ST_RUN  = RUN;
   localparam logic [1:0] ST_DONE = DONE;
   logic [1:0]       r_state;
   logic [WIDTH-1:0] r_a_sr, r_b_sr, r_d_sr, r_diff;
   logic [CW-1:0]    r_cnt;
   logic             r_br, r_a_msb, r_b_msb, r_bout, r_ovf;
   logic             w_d, w_bo, w_last;
   logic [WIDTH-1:0] w_d_next;
   full_subtractor_cell u_fsc (.x(r_a_sr[0]), .y(r_b_sr[0]), .bi(r_br), .d(w_d), .bo(w_bo));
   assign w_last        = r_cnt == CW'(WIDTH - 1);
   assign w_d_next      = {w_d, r_d_sr[WIDTH-1:1]};
   assign bus.in_ready  = (r_state == ST_IDLE) & ~rst;
   assign bus.out_valid = r_state == ST_DONE;
   assign bus.diff      = r_diff;
   assign bus.bout      = r_bout;
   assign bus.ovf       = r_ovf;
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= ST_IDLE;
         r_a_sr  <= '0;
         r_b_sr  <= '0;
         r_d_sr  <= '0;
         r_diff  <= '0;
         r_cnt   <= '0;
         r_br    <= 1'b0;
         r_a_msb <= 1'b0;
         r_b_msb <= 1'b0;
         r_bout  <= 1'b0;
         r_ovf   <= 1'b0;
      end else begin
         case (r_state)
            ST_IDLE: if (bus.in_valid) begin
               r_a_sr  <= bus.a;
               r_b_sr  <= bus.b;
               r_br    <= bus.bin;
               r_a_msb <= bus.a[WIDTH-1];
               r_b_msb <= bus.b[WIDTH-1];
               r_cnt   <= '0;
               r_state <= ST_RUN;
            end
            ST_RUN: begin
               r_a_sr <= r_a_sr >> 1;
               r_b_sr <= r_b_sr >> 1;
               r_d_sr <= w_d_next;
               r_br   <= w_bo;
               r_cnt  <= w_last ? r_cnt : r_cnt + CW'(1);
               // w_d is the result MSB on the last bit, so overflow is known here
               if (w_last) begin
                  r_diff  <= w_d_next;
                  r_bout  <= w_bo;
                  r_ovf   <= (r_a_msb ^ r_b_msb) & (w_d ^ r_a_msb);
                  r_state <= ST_DONE;
               end
            end
            ST_DONE: r_state <= bus.out_ready ? ST_IDLE : ST_DONE;
            default: r_state <= ST_IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_serial_subtractor_16.sv
// tb_serial_subtractor_16: directed and streamed checks of the serial subtractor against an arithmetic model
module tb_serial_subtractor_16;
   localparam int WIDTH = 16;
   logic clk = 1'b0;
   logic rst = 1'b1;
   int   cyc = 0;
   int   n_cmp = 0;
   int   n_err = 0;
   serial_subtractor_16_if #(.WIDTH(WIDTH)) bus ();
   serial_subtractor_16 #(.WIDTH(WIDTH)) dut (.clk(clk), .rst(rst), .bus(bus));
   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;
   typedef struct {logic [17:0] res; int acc;} exp_t;
   exp_t q[$];
   logic seen = 1'b0;
   // result packed as {ovf, bout, diff}
   function automatic logic [17:0] model(input logic [15:0] a, input logic [15:0] b, input logic bi);
      logic [16:0] r;
      logic        o;
      r = {1'b0, a} - {1'b0, b} - {16'd0, bi};
      o = (a[15] != b[15]) && (r[15] != a[15]);
      return {o, r};
   endfunction
   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
      end
   endtask
   always @(negedge clk) begin
      if (rst) begin
         q.delete();
         seen = 1'b0;
      end else begin
         if (bus.out_valid) begin
            if (q.size() == 0) chk("spurious_out_valid", 32'd1, 32'd0);
            else begin
               chk("mon_result", {14'd0, bus.ovf, bus.bout, bus.diff}, {14'd0, q[0].res});
               if (!seen) chk("mon_latency", cyc - q[0].acc, WIDTH + 1);
               seen = 1'b1;
               if (bus.out_ready) begin
                  void'(q.pop_front());
                  seen = 1'b0;
               end
            end
         end
         if (bus.in_valid && bus.in_ready) q.push_back('{model(bus.a, bus.b, bus.bin), cyc});
      end
   end
   task automatic wait_in_ready();
      int k = 0;
      do @(negedge clk); while (!bus.in_ready && ++k < 60);
      if (!bus.in_ready) chk("in_ready_timeout", 32'd0, 32'd1);
   endtask
   task automatic wait_out_valid();
      int k = 0;
      do @(negedge clk); while (!bus.out_valid && ++k < 60);
      chk("out_valid_seen", {31'd0, bus.out_valid}, 32'd1);
   endtask
   task automatic do_op(input string nm, input logic [15:0] a, input logic [15:0] b, input logic bi, input logic [17:0] exp);
      @(posedge clk); #1;
      bus.a = a;
      bus.b = b;
      bus.bin = bi;
      bus.in_valid = 1'b1;
      wait_in_ready();
      @(posedge clk); #1;
      bus.in_valid = 1'b0;
      bus.a = 16'($urandom);
      bus.b = 16'($urandom);
      bus.bin = 1'($urandom);
      wait_out_valid();
      chk(nm, {14'd0, bus.ovf, bus.bout, bus.diff}, {14'd0, exp});
   endtask
   initial begin
      logic [17:0] held;
      int          last;
      int          nv;
      int          k;
      bus.in_valid = 1'b0;
      bus.a = '0;
      bus.b = '0;
      bus.bin = 1'b0;
      bus.out_ready = 1'b1;
      chk("model_basic", model(16'h0005, 16'h0003, 1'b0), {2'b00, 16'h0002});
      chk("model_wrap", model(16'h0000, 16'h0001, 1'b0), {2'b01, 16'hFFFF});
      chk("model_eq_bin", model(16'h1234, 16'h1234, 1'b1), {2'b01, 16'hFFFF});
      chk("model_ovf_neg", model(16'h8000, 16'h0001, 1'b0), {2'b10, 16'h7FFF});
      chk("model_ovf_pos", model(16'h7FFF, 16'hFFFF, 1'b0), {2'b11, 16'h8000});
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("rst_in_ready", {31'd0, bus.in_ready}, 32'd0);
      chk("rst_outputs", {13'd0, bus.out_valid, bus.ovf, bus.bout, bus.diff}, 32'd0);
      @(posedge clk); #1;
      rst = 1'b0;
      @(negedge clk);
      chk("idle_in_ready", {31'd0, bus.in_ready}, 32'd1);
      do_op("basic", 16'h0005, 16'h0003, 1'b0, {2'b00, 16'h0002});
      do_op("wrap", 16'h0000, 16'h0001, 1'b0, {2'b01, 16'hFFFF});
      do_op("eq_bin", 16'h1234, 16'h1234, 1'b1, {2'b01, 16'hFFFF});
      do_op("bin_only", 16'h0000, 16'h0000, 1'b1, {2'b01, 16'hFFFF});
      do_op("ovf_neg", 16'h8000, 16'h0001, 1'b0, {2'b10, 16'h7FFF});
      do_op("ovf_pos", 16'h7FFF, 16'hFFFF, 1'b0, {2'b11, 16'h8000});
      // backpressure
      @(posedge clk); #1;
      bus.out_ready = 1'b0;
      do_op("bp_result", 16'h1000, 16'h0001, 1'b0, {2'b00, 16'h0FFF});
      held = {bus.ovf, bus.bout, bus.diff};
      for (int i = 0; i < 5; i++) begin
         @(posedge clk); #1;
         bus.in_valid = (i == 1);
         bus.a = 16'hAAAA;
         bus.b = 16'h5555;
         @(negedge clk);
         chk("bp_hold", {14'd0, bus.ovf, bus.bout, bus.diff}, {14'd0, held});
         chk("bp_state", {30'd0, bus.out_valid, bus.in_ready}, 32'd2);
      end
      @(posedge clk); #1;
      bus.in_valid = 1'b0;
      bus.out_ready = 1'b1;
      @(negedge clk);
      @(negedge clk);
      chk("bp_release", {30'd0, bus.out_valid, bus.in_ready}, 32'd1);
      // reset at RUN bit 8
      @(posedge clk); #1;
      bus.a = 16'h1111;
      bus.b = 16'h0101;
      bus.bin = 1'b0;
      bus.in_valid = 1'b1;
      wait_in_ready();
      @(posedge clk); #1;
      bus.in_valid = 1'b0;
      repeat (8) @(posedge clk);
      #1 rst = 1'b1;
      @(negedge clk);
      chk("midrst_in_ready", {31'd0, bus.in_ready}, 32'd0);
      @(posedge clk); #1;
      rst = 1'b0;
      @(negedge clk);
      chk("midrst_outputs", {13'd0, bus.out_valid, bus.ovf, bus.bout, bus.diff}, 32'd0);
      chk("midrst_idle", {31'd0, bus.in_ready}, 32'd1);
      nv = 0;
      repeat (20) begin
         @(negedge clk);
         nv += int'(bus.out_valid);
      end
      chk("midrst_no_valid", nv, 0);
      do_op("after_rst", 16'h00FF, 16'h000F, 1'b0, {2'b00, 16'h00F0});
      // back-to-back random stream
      last = 0;
      for (int i = 0; i < 1000; i++) begin
         @(posedge clk); #1;
         bus.a = 16'($urandom);
         bus.b = 16'($urandom);
         bus.bin = 1'($urandom);
         bus.in_valid = 1'b1;
         wait_in_ready();
         if (i > 0) chk("accept_spacing", cyc - last, WIDTH + 2);
         last = cyc;
      end
      @(posedge clk); #1;
      bus.in_valid = 1'b0;
      k = 0;
      while (q.size() != 0 && k < 100) begin
         @(negedge clk);
         k++;
      end
      chk("drain", q.size(), 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
